md_unit: RTL and testbench

Execute-stage multiply/divide unit for the 5-stage MIPS pipeline. It owns the HI/LO registers and runs multi-cycle mult/multu/div/divu. It generates `E_MD_stall`, which the hazard controller ORs into the pipeline stall, so any MD-class instruction in D is held while an operation is in flight. It returns mfhi/mflo data to the E-stage result mux.

---
 rtl/md_unit.sv | 139 +++++++++++++
 tb/tb_md_unit.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit for the E stage: owns HI/LO, holds results in
// pending registers until the busy countdown expires, and raises the D-stage stall.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_md_op,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        D_is_md,
  output logic        start,
  output logic        busy,
  output logic        E_MD_stall,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] E_md_out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [31:0]        hi_reg, hi_next, lo_reg, lo_next;
  logic [31:0]        p_hi_reg, p_hi_next, p_lo_reg, p_lo_next;

  logic        is_arith, is_mult;
  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, divisor, q_u, r_u;
  logic        neg_q, neg_r;
  logic [31:0] res_hi, res_lo;

  assign is_arith   = (E_md_op >= OP_MULT) && (E_md_op <= OP_DIVU);
  assign is_mult    = (E_md_op == OP_MULT) || (E_md_op == OP_MULTU);
  assign busy       = (state_reg == RUN);
  assign start      = is_arith && !busy;
  assign E_MD_stall = D_is_md && (start || busy);
  assign HI         = hi_reg;
  assign LO         = lo_reg;

  // Signed divide works on magnitudes so 0x80000000 / -1 wraps cleanly instead of overflowing.
  always_comb begin
    prod_s  = $signed({{32{E_A[31]}}, E_A}) * $signed({{32{E_B[31]}}, E_B});
    prod_u  = {32'b0, E_A} * {32'b0, E_B};
    a_mag   = ((E_md_op == OP_DIV) && E_A[31]) ? (32'd0 - E_A) : E_A;
    b_mag   = ((E_md_op == OP_DIV) && E_B[31]) ? (32'd0 - E_B) : E_B;
    divisor = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_u     = a_mag / divisor;
    r_u     = a_mag % divisor;
    neg_q   = (E_md_op == OP_DIV) && (E_A[31] ^ E_B[31]);
    neg_r   = (E_md_op == OP_DIV) && E_A[31];
    res_hi  = hi_reg;
    res_lo  = lo_reg;
    case (E_md_op)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV, OP_DIVU: begin
        // Divide by zero re-commits the current HI/LO, leaving them unchanged.
        if (E_B != 32'd0) begin
          res_lo = neg_q ? (32'd0 - q_u) : q_u;
          res_hi = neg_r ? (32'd0 - r_u) : r_u;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    p_hi_next  = p_hi_reg;
    p_lo_next  = p_lo_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          p_hi_next  = res_hi;
          p_lo_next  = res_lo;
          cnt_next   = is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
          state_next = RUN;
        end else if (E_md_op == OP_MTHI) begin
          hi_next = E_A;
        end else if (E_md_op == OP_MTLO) begin
          lo_next = E_A;
        end
      end
      RUN: begin
        cnt_next = cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1)) begin
          hi_next    = p_hi_reg;
          lo_next    = p_lo_reg;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      p_hi_reg  <= '0;
      p_lo_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      p_hi_reg  <= p_hi_next;
      p_lo_reg  <= p_lo_next;
    end
  end

  always_comb begin
    case (E_md_op)
      OP_MFHI: E_md_out = hi_reg;
      OP_MFLO: E_md_out = lo_reg;
      default: E_md_out = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: multiply/divide latency and results, stall behaviour,
// HI/LO moves, divide by zero, reset mid-operation and ops ignored while busy.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  E_md_op;
  logic [31:0] E_A, E_B;
  logic        D_is_md;
  logic        start, busy, E_MD_stall;
  logic [31:0] HI, LO, E_md_out;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi, m_lo;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .E_md_op(E_md_op), .E_A(E_A), .E_B(E_B),
    .D_is_md(D_is_md), .start(start), .busy(busy), .E_MD_stall(E_MD_stall),
    .HI(HI), .LO(LO), .E_md_out(E_md_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one arithmetic op and follow it through every busy cycle to commit.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic dmd, input int n,
                        input logic [31:0] eh, input logic [31:0] el);
    E_md_op = op; E_A = a; E_B = b; D_is_md = dmd;
    #1;
    check({tag, " start"}, 32'(start), 32'd1);
    check({tag, " stall t"}, 32'(E_MD_stall), 32'(dmd));
    step();
    E_md_op = 4'd0; E_A = 32'd0; E_B = 32'd0;
    #1;
    for (int i = 1; i <= n; i++) begin
      check($sformatf("%s busy t+%0d", tag, i), 32'(busy), 32'd1);
      check($sformatf("%s stall t+%0d", tag, i), 32'(E_MD_stall), 32'(dmd));
      check($sformatf("%s HI held t+%0d", tag, i), HI, m_hi);
      check($sformatf("%s LO held t+%0d", tag, i), LO, m_lo);
      step();
    end
    E_md_op = 4'd5;
    #1;
    check({tag, " busy done"}, 32'(busy), 32'd0);
    check({tag, " stall done"}, 32'(E_MD_stall), 32'd0);
    check({tag, " HI"}, HI, eh);
    check({tag, " LO"}, LO, el);
    check({tag, " mfhi"}, E_md_out, eh);
    m_hi = eh; m_lo = el;
    E_md_op = 4'd0; D_is_md = 1'b0;
  endtask

  initial begin
    reset = 1'b1; E_md_op = 4'd0; E_A = 32'd0; E_B = 32'd0; D_is_md = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    step(); step();
    reset = 1'b0;
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset HI", HI, 32'd0);
    check("reset LO", LO, 32'd0);
    check("reset out", E_md_out, 32'd0);
    D_is_md = 1'b1;
    #1;
    check("idle stall", 32'(E_MD_stall), 32'd0);
    D_is_md = 1'b0;

    run_op("mult", 4'd1, 32'hFFFFFFFD, 32'd5, 1'b1, 5, 32'hFFFFFFFF, 32'hFFFFFFF1);
    run_op("multu", 4'd2, 32'hFFFFFFFD, 32'd5, 1'b0, 5, 32'h00000004, 32'hFFFFFFF1);
    run_op("divu", 4'd4, 32'd7, 32'd2, 1'b0, 10, 32'd1, 32'd3);
    run_op("div", 4'd3, 32'hFFFFFFF9, 32'd2, 1'b1, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 10, 32'd0, 32'h80000000);

    // HI/LO moves, then divide by zero must leave them untouched.
    E_md_op = 4'd7; E_A = 32'h12345678;
    #1;
    check("mthi start", 32'(start), 32'd0);
    step();
    E_md_op = 4'd5; E_A = 32'd0;
    #1;
    check("mfhi after mthi", E_md_out, 32'h12345678);
    E_md_op = 4'd8; E_A = 32'hCAFEF00D;
    step();
    E_md_op = 4'd6; E_A = 32'd0;
    #1;
    check("mflo after mtlo", E_md_out, 32'hCAFEF00D);
    check("HI kept by mtlo", HI, 32'h12345678);
    m_hi = 32'h12345678; m_lo = 32'hCAFEF00D;
    run_op("div0", 4'd3, 32'd99, 32'd0, 1'b0, 10, 32'h12345678, 32'hCAFEF00D);
    run_op("divu0", 4'd4, 32'd99, 32'd0, 1'b1, 10, 32'h12345678, 32'hCAFEF00D);

    // Ops presented while busy are ignored; the countdown is unaffected.
    E_md_op = 4'd1; E_A = 32'd2; E_B = 32'd3;
    step();
    for (int i = 1; i <= 5; i++) begin
      case (i)
        1: begin E_md_op = 4'd2; E_A = 32'hFFFFFFFF; E_B = 32'hFFFFFFFF; end
        2: begin E_md_op = 4'd7; E_A = 32'h0000DEAD; end
        3: begin E_md_op = 4'd8; E_A = 32'h0000BEEF; end
        4: begin E_md_op = 4'd3; E_A = 32'd9; E_B = 32'd4; end
        default: begin E_md_op = 4'd1; E_A = 32'd7; E_B = 32'd7; end
      endcase
      #1;
      check($sformatf("ign start t+%0d", i), 32'(start), 32'd0);
      check($sformatf("ign busy t+%0d", i), 32'(busy), 32'd1);
      check($sformatf("ign HI t+%0d", i), HI, 32'h12345678);
      step();
    end
    E_md_op = 4'd0; E_A = 32'd0; E_B = 32'd0;
    #1;
    check("ign busy done", 32'(busy), 32'd0);
    check("ign HI", HI, 32'd0);
    check("ign LO", LO, 32'd6);

    // Reset during a divide discards the pending result.
    E_md_op = 4'd4; E_A = 32'd100; E_B = 32'd7;
    step();
    E_md_op = 4'd0; E_A = 32'd0; E_B = 32'd0;
    step(); step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("rst busy t+5", 32'(busy), 32'd0);
    check("rst HI t+5", HI, 32'd0);
    check("rst LO t+5", LO, 32'd0);
    for (int i = 0; i < 7; i++) step();
    check("rst busy t+12", 32'(busy), 32'd0);
    check("rst HI t+12", HI, 32'd0);
    check("rst LO t+12", LO, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
